// File: rtl/operand_loader.sv
// Four-slot operand loader: sequentially captures words into out0..out3 and flags full.
// Optional OPERAND_LOADER_DIRECT_EN adds wr_sel/wr_direct for addressed writes into any slot.
module operand_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
`ifdef OPERAND_LOADER_DIRECT_EN
  input  logic [1:0]       wr_sel,
  input  logic             wr_direct,
`endif
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [1:0]       slot,
  output logic             full,
  output logic             load_done
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] slots_q [4];
  logic [WIDTH-1:0] slots_d [4];
  logic             direct;
  logic             accept;

`ifdef OPERAND_LOADER_DIRECT_EN
  assign direct = wr_direct;
`else
  assign direct = 1'b0;
`endif

  // A direct write is accepted in any state, so it also opens in_ready while FULL.
  assign in_ready = (state_q != FULL) | direct;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    done_d  = 1'b0;
    slots_d = slots_q;
    if (clear) begin
      state_d = EMPTY;
      slot_d  = '0;
      slots_d = '{default: '0};
    end else if (accept) begin
      if (direct) begin
`ifdef OPERAND_LOADER_DIRECT_EN
        slots_d[wr_sel] = in_data;
`endif
      end else begin
        slots_d[slot_q] = in_data;
        slot_d          = slot_q + 2'd1;
        if (slot_q == 2'd3) begin
          state_d = FULL;
          done_d  = 1'b1;
        end else begin
          state_d = FILLING;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      slot_q  <= '0;
      done_q  <= 1'b0;
      slots_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      done_q  <= done_d;
      slots_q <= slots_d;
    end
  end

  assign out0      = slots_q[0];
  assign out1      = slots_q[1];
  assign out2      = slots_q[2];
  assign out3      = slots_q[3];
  assign slot      = slot_q;
  assign full      = (state_q == FULL);
  assign load_done = done_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader; inputs change 1ns after each rising edge.
module tb_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       clear;
`ifdef OPERAND_LOADER_DIRECT_EN
  logic [1:0] wr_sel;
  logic       wr_direct;
`endif
  logic [7:0] out0, out1, out2, out3;
  logic [1:0] slot;
  logic       full;
  logic       load_done;

  int vectors    = 0;
  int miscompares = 0;

  operand_loader #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
`ifdef OPERAND_LOADER_DIRECT_EN
    .wr_sel    (wr_sel),
    .wr_direct (wr_direct),
`endif
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .slot      (slot),
    .full      (full),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, ".out0"}, out0, e0);
    chk({tag, ".out1"}, out1, e1);
    chk({tag, ".out2"}, out2, e2);
    chk({tag, ".out3"}, out3, e3);
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    clear    = 1'b0;
`ifdef OPERAND_LOADER_DIRECT_EN
    wr_sel    = '0;
    wr_direct = 1'b0;
`endif
    #3;
    chk_outs("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset.slot", {6'b0, slot}, 8'd0);
    chk("reset.full", {7'b0, full}, 8'd0);
    chk("reset.load_done", {7'b0, load_done}, 8'd0);
    chk("reset.in_ready", {7'b0, in_ready}, 8'd1);
    step();
    rst_n = 1'b1;

    // Four consecutive words fill all slots
    in_valid = 1'b1;
    in_data = 8'h11; step();
    chk("fill1.slot", {6'b0, slot}, 8'd1);
    chk("fill1.full", {7'b0, full}, 8'd0);
    in_data = 8'h22; step();
    chk("fill2.slot", {6'b0, slot}, 8'd2);
    in_data = 8'h33; step();
    chk("fill3.slot", {6'b0, slot}, 8'd3);
    chk("fill3.load_done", {7'b0, load_done}, 8'd0);
    in_data = 8'h44; step();
    in_valid = 1'b0;
    chk_outs("fill4", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("fill4.slot", {6'b0, slot}, 8'd0);
    chk("fill4.full", {7'b0, full}, 8'd1);
    chk("fill4.load_done", {7'b0, load_done}, 8'd1);
    chk("fill4.in_ready", {7'b0, in_ready}, 8'd0);
    step();
    chk("fill4+1.load_done", {7'b0, load_done}, 8'd0);
    chk("fill4+1.full", {7'b0, full}, 8'd1);

    // Word offered while FULL is ignored
    in_valid = 1'b1;
    in_data  = 8'hAA;
    #1;
    chk("fullign.in_ready", {7'b0, in_ready}, 8'd0);
    step();
    in_valid = 1'b0;
    chk_outs("fullign", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("fullign.slot", {6'b0, slot}, 8'd0);
    chk("fullign.full", {7'b0, full}, 8'd1);
    chk("fullign.load_done", {7'b0, load_done}, 8'd0);

    clear = 1'b1; step(); clear = 1'b0;
    chk_outs("clr1", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("clr1.full", {7'b0, full}, 8'd0);
    chk("clr1.in_ready", {7'b0, in_ready}, 8'd1);

    // Clear wins over a simultaneous accept
    push(8'h05);
    push(8'h06);
    chk_outs("pre_clr", 8'h05, 8'h06, 8'h00, 8'h00);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h07;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk_outs("clr_pri", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("clr_pri.slot", {6'b0, slot}, 8'd0);
    chk("clr_pri.full", {7'b0, full}, 8'd0);
    step();
    chk_outs("clr_hold", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("clr_hold.slot", {6'b0, slot}, 8'd0);

    // Gapped valid: accepts on cycles 1, 4, 5, 9 only
    for (int c = 1; c <= 9; c++) begin
      in_valid = (c == 1) || (c == 4) || (c == 5) || (c == 9);
      in_data  = 8'h30 + 8'(c);
      step();
      if (c == 3) chk("gap3.slot", {6'b0, slot}, 8'd1);
      if (c == 8) chk("gap8.slot", {6'b0, slot}, 8'd3);
    end
    in_valid = 1'b0;
    chk_outs("gap", 8'h31, 8'h34, 8'h35, 8'h39);
    chk("gap.full", {7'b0, full}, 8'd1);
    chk("gap.load_done", {7'b0, load_done}, 8'd1);

    clear = 1'b1; step(); clear = 1'b0;

    // Asynchronous reset mid-fill
    push(8'h61);
    push(8'h62);
    push(8'h63);
    chk("prerst.slot", {6'b0, slot}, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("async_rst.slot", {6'b0, slot}, 8'd0);
    chk("async_rst.in_ready", {7'b0, in_ready}, 8'd1);
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    chk("rst_edge.out0", out0, 8'h00);
    chk("rst_edge.slot", {6'b0, slot}, 8'd0);
    rst_n = 1'b1;
    push(8'h71);
    chk("post_rst1.slot", {6'b0, slot}, 8'd1);
    push(8'h72);
    push(8'h73);
    push(8'h74);
    chk_outs("post_rst", 8'h71, 8'h72, 8'h73, 8'h74);
    chk("post_rst.full", {7'b0, full}, 8'd1);
    chk("post_rst.load_done", {7'b0, load_done}, 8'd1);
    step();

`ifdef OPERAND_LOADER_DIRECT_EN
    // Direct write into slot 2 while FULL
    wr_direct = 1'b1; wr_sel = 2'd2; in_valid = 1'b1; in_data = 8'h5A;
    #1;
    chk("direct.in_ready", {7'b0, in_ready}, 8'd1);
    step();
    wr_direct = 1'b0; in_valid = 1'b0;
    chk_outs("direct", 8'h71, 8'h72, 8'h5A, 8'h74);
    chk("direct.slot", {6'b0, slot}, 8'd0);
    chk("direct.full", {7'b0, full}, 8'd1);
    chk("direct.load_done", {7'b0, load_done}, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
